// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronised, glitch-filtered frame capture,
// break-code tagging, show-ahead FIFO and WASD direction tracking.
// Odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL,
  input  logic       SDA,
  output logic [7:0] code_data,
  output logic       code_break,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [2:0] direction,
  output logic       frame_err,
  output logic       fifo_overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] DIR_W   = 3'b011;
  localparam logic [2:0] DIR_A   = 3'b010;
  localparam logic [2:0] DIR_S   = 3'b001;
  localparam logic [2:0] DIR_D   = 3'b000;
  localparam logic [2:0] DIR_RST = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  logic           scl_s1_q, scl_s2_q;
  logic           sda_s1_q, sda_s2_q;
  logic           scl_f_q, scl_f_d;
  logic [FCW-1:0] flt_cnt_q, flt_cnt_d;
  logic           sample_ev;

  state_t         state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]     data_q, data_d;
  logic           stop_q, stop_d;
  logic           err_q, err_d;
  logic           brk_q, brk_d;
  logic [2:0]     dir_q, dir_d;
  logic           ovf_q, ovf_d;
  logic           frame_ok;
  logic           par_ok;

  logic [8:0]     mem_q [FIFO_DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           empty, full;
  logic           good, push, pop, wr_en;

  // The filtered level flips only after FILTER_LEN samples disagree with it
  always_comb begin
    scl_f_d   = scl_f_q;
    flt_cnt_d = '0;
    if (scl_s2_q != scl_f_q) begin
      if (flt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        scl_f_d = scl_s2_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  assign sample_ev = scl_f_q & ~scl_f_d;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  assign par_ok = ^{par_q, data_q};
`else
  assign par_ok = 1'b1;
`endif

  assign frame_ok = stop_q & par_ok;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    data_d    = data_q;
    stop_d    = stop_q;
    err_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        if (sample_ev && !sda_s2_q) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (sample_ev) begin
          to_cnt_d  = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q < 4'd8) begin
            data_d = {sda_s2_q, data_q[7:1]};
          end
`ifdef PS2_PARITY_CHECK_EN
          if (bit_cnt_q == 4'd8) begin
            par_d = sda_s2_q;
          end
`endif
          if (bit_cnt_q == 4'd9) begin
            stop_d  = sda_s2_q;
            state_d = CHECK;
          end
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        err_d     = ~frame_ok;
      end
      default: state_d = IDLE;
    endcase
  end

  assign good  = (state_q == CHECK) && frame_ok;
  assign push  = good && (data_q != 8'hF0);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && code_ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    brk_d    = brk_q;
    dir_d    = dir_q;
    ovf_d    = push && full && !pop;
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    if (good) begin
      brk_d = (data_q == 8'hF0);
    end
    if (push && !brk_q) begin
      unique case (1'b1)
        (data_q == 8'h1D): if (dir_q != DIR_S) dir_d = DIR_W;
        (data_q == 8'h1C): if (dir_q != DIR_D) dir_d = DIR_A;
        (data_q == 8'h1B): if (dir_q != DIR_W) dir_d = DIR_S;
        (data_q == 8'h23): if (dir_q != DIR_A) dir_d = DIR_D;
        (data_q == 8'h29): dir_d = DIR_RST;
        default: dir_d = dir_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q  <= 1'b1;
      scl_s2_q  <= 1'b1;
      sda_s1_q  <= 1'b1;
      sda_s2_q  <= 1'b1;
      scl_f_q   <= 1'b1;
      flt_cnt_q <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      data_q    <= '0;
      stop_q    <= 1'b0;
      err_q     <= 1'b0;
      brk_q     <= 1'b0;
      dir_q     <= DIR_S;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      scl_s1_q  <= SCL;
      scl_s2_q  <= scl_s1_q;
      sda_s1_q  <= SDA;
      sda_s2_q  <= sda_s1_q;
      scl_f_q   <= scl_f_d;
      flt_cnt_q <= flt_cnt_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      data_q    <= data_d;
      stop_q    <= stop_d;
      err_q     <= err_d;
      brk_q     <= brk_d;
      dir_q     <= dir_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {brk_q, data_q};
    end
  end

  assign code_valid    = !empty;
  assign {code_break, code_data} =
    empty ? 9'h000 : mem_q[rd_ptr_q[AW-1:0]];
  assign direction     = dir_q;
  assign frame_err     = err_q;
  assign fifo_overflow = ovf_q;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive identical synchronised ps2_clk samples required before the filtered level changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: clk cycles without a filtered ps2_clk falling edge before an in-progress frame is aborted.
REQ-003 Parameter FIFO_DEPTH, default 8: scan-code FIFO entries; power of two, minimum 2.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 SCL  in  1  PS/2 clock line, asynchronous to clk.
REQ-007 SDA  in  1  PS/2 data line, asynchronous to clk.
REQ-008 code_data  out  8  scan code at FIFO head.
REQ-009 code_break  out  1  head entry was preceded by 0xF0 (key release).
REQ-010 code_valid  out  1  FIFO not empty.
REQ-011 code_ready  in  1  consumer pop request.
REQ-012 direction  out  3  w=3'b011, a=3'b010, s=3'b001, d=3'b000, rst=3'b100.
REQ-013 frame_err  out  1  one-cycle pulse on a bad or aborted frame.
REQ-014 fifo_overflow  out  1  one-cycle pulse when a code is dropped because the FIFO is full.

Function
REQ-015 SCL and SDA shall each pass through a 2-flop synchroniser; SCL shall then be glitch-filtered per FILTER_LEN; a sample event is a 1->0 transition of the filtered SCL.
REQ-016 FSM states IDLE, RECV, CHECK; IDLE->RECV on a sample event with SDA=0 (start bit); a sample event with SDA=1 in IDLE shall be ignored.
REQ-017 RECV shall shift 8 data bits LSB first, then parity, then stop; on the 10th sample event after start it shall go to CHECK.
REQ-018 CHECK lasts exactly one cycle, then IDLE; a frame is good if stop=1 and the parity condition (REQ-029/030) holds.
REQ-019 Frame latency: stop-bit sample event at cycle N -> CHECK at N+1 -> FIFO/direction/pulse outputs visible at N+2.
REQ-020 Bad frame: no FIFO write, no direction change, frame_err=1 for one cycle.
REQ-021 Timeout: TIMEOUT_CYCLES cycles in RECV with no sample event -> abort to IDLE, partial frame discarded, frame_err pulse; counter cleared on every sample event.
REQ-022 Good code 0xF0 shall set break_pending and not be written to the FIFO; any other good code shall be written as {break_pending, code}, then break_pending cleared.
REQ-023 FIFO is show-ahead: code_data/code_break reflect the head whenever code_valid=1; pop when code_valid && code_ready.
REQ-024 Write when full without a same-cycle pop: entry dropped, fifo_overflow pulse; write and pop in the same cycle while full: both succeed, no overflow; pop when empty: ignored.
REQ-025 Direction update on good make codes only (break flag clear), independent of FIFO space: 0x1D->w unless direction=s; 0x1C->a unless direction=d; 0x1B->s unless direction=w; 0x23->d unless direction=a; blocked reversals leave direction unchanged.
REQ-026 0x29 shall set direction=rst; from rst any of w/a/s/d shall be accepted; all other codes leave direction unchanged.

Reset
REQ-027 On rst=1 at a clk edge: FSM=IDLE, bit and timeout counters 0, break_pending 0, FIFO empty (code_valid=0), code_data=8'h00, code_break=0, frame_err=0, fifo_overflow=0, direction=s (3'b001), filter and synchroniser state=1.
REQ-028 rst asserted mid-frame shall discard the partial frame without frame_err; reception resumes with the next start bit after rst deasserts.

Configuration
REQ-029 With PS2_PARITY_CHECK_EN defined: the parity bit shall make the 9 data+parity bits odd; otherwise the frame is bad.
REQ-030 Without PS2_PARITY_CHECK_EN: parity bit sampled but ignored; only the stop bit and timeout produce frame_err.

Verification
REQ-031 Frame 0x1D, correct parity, stop=1, direction=s -> direction stays s, FIFO head 0x1D, code_break=0; then 0x23 -> direction=d.
REQ-032 Frames 0xF0, 0x1C -> single FIFO entry 0x1C with code_break=1; direction unchanged.
REQ-033 With PS2_PARITY_CHECK_EN, frame 0x1B with even parity -> frame_err pulse, FIFO empty, direction unchanged; without the macro -> entry 0x1B accepted.
REQ-034 Start bit plus 4 data bits, then SCL held high for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next full frame 0x29 -> direction=rst.
REQ-035 FIFO_DEPTH=8, code_ready=0, 9 good frames -> code_valid=1, one fifo_overflow pulse, head = first code; drain with code_ready=1 -> 8 codes in order.
REQ-036 1-cycle SCL glitches shorter than FILTER_LEN during a frame -> no extra bits, frame received correctly.
